rom_access_seq: RTL and testbench
=================================

// Module: rom_access_seq
// PURPOSE
//  Bus sequencer for the shared 16-bit ROM/SRAM. Arbitrates SNES and MCU accesses and generates
//  the control strobes consumed by the data path: MODE, MCU_WRITE, the four *_TO_* latch strobes,
//  and the ROM_OE_N/ROM_WE_N pins. SNES accesses have fixed priority. MCU accesses are served
//  from request pulses and acknowledged with MCU_RDY.
// PARAMETERS
//  RD_CYCLES  4  cycles ROM_OE_N is held low per read; latch strobe fires on the last one (min 2)
//  WR_CYCLES  4  cycles ROM_WE_N is held low per write (min 1)
//  WR_DELAY   3  cycles from SNES write detect to the SNES_DATA_TO_MEM capture (min 1)
// PORTS
//  CLK                   in   1  system clock
//  RST_N                 in   1  asynchronous reset, active low
//  SNES_READ             in   1  SNES /RD pin, async, active low
//  SNES_WRITE            in   1  SNES /WR pin, async, active low
//  MCU_RRQ               in   1  MCU read request, 1-cycle pulse
//  MCU_WRQ               in   1  MCU write request, 1-cycle pulse
//  MCU_RDY               out  1  1-cycle pulse: MCU access complete
//  MCU_BUSY              out  1  MCU request pending or in service
//  MODE                  out  1  1 = MCU owns the ROM bus, 0 = SNES
//  MCU_WRITE             out  1  active-low MCU write-data drive enable
//  ROM_OE_N              out  1  ROM output enable, active low
//  ROM_WE_N              out  1  ROM write enable, active low
//  SNES_DATA_TO_MEM      out  1  capture SNES write byte
//  MCU_DATA_TO_MEM       out  1  capture MCU write byte
//  ROM_DATA_TO_SNES_MEM  out  1  latch ROM byte for SNES
//  ROM_DATA_TO_MCU_MEM   out  1  latch ROM byte for MCU
// BEHAVIOUR
//  Reset (async): state IDLE; pending flags 0; counter 0. All synchroniser flops = 1, so there is
//   no false edge. MODE=0, MCU_WRITE=1, ROM_OE_N=1, ROM_WE_N=1. All strobes, MCU_RDY and MCU_BUSY = 0.
//   Reset mid-access: the access is abandoned and ROM_WE_N/ROM_OE_N deassert immediately.
//  Sync: SNES_READ and SNES_WRITE each pass a 3-flop chain (s1,s2,s3); falling edge = s3 & ~s2,
//   a registered signal. It sets snes_rd_pend / snes_wr_pend.
//  MCU_RRQ / MCU_WRQ set mcu_rd_pend / mcu_wr_pend. A request whose flag is already set is dropped.
//  MCU_BUSY = mcu_rd_pend | mcu_wr_pend | (state in M_RD, M_WR).
//  FSM, registered outputs. Counter cnt resets to 0 on every state entry.
//   IDLE: priority snes_rd_pend > snes_wr_pend > mcu_rd_pend > mcu_wr_pend.
//    The winning flag clears on the transition cycle.
//   S_RD (MODE=0): ROM_OE_N=0 for RD_CYCLES cycles. ROM_DATA_TO_SNES_MEM=1 on cnt==RD_CYCLES-1.
//    Then -> IDLE.
//   S_WR (MODE=0): idle for cnt<WR_DELAY. SNES_DATA_TO_MEM=1 on cnt==WR_DELAY-1.
//    ROM_WE_N=0 for cnt in [WR_DELAY, WR_DELAY+WR_CYCLES-1]. Then -> IDLE.
//   M_RD (MODE=1): ROM_OE_N=0 for RD_CYCLES. ROM_DATA_TO_MCU_MEM=1 on the last cycle.
//    -> IDLE with MCU_RDY=1 for one cycle.
//   M_WR (MODE=1): MCU_DATA_TO_MEM=1 at cnt==0. ROM_WE_N=0 and MCU_WRITE=0 for cnt 1..WR_CYCLES.
//    -> IDLE with MCU_RDY=1 for one cycle.
//  Strobes are single-cycle and mutually exclusive. OE and WE are never both low.
//  MODE changes only on an IDLE cycle; one IDLE cycle separates consecutive accesses.
//  SNES edges during an M_* state are latched and served right after it.
//   Worst-case SNES service delay = WR_CYCLES+2 cycles after detect.
//  Simultaneous MCU_RRQ and MCU_WRQ: both latch; read is served first, then write;
//   two MCU_RDY pulses.
//  Simultaneous SNES read and write edges: read first.
//  A second edge of the same type while its flag is set merges (no queue).
//  Counter width = $clog2(WR_DELAY+WR_CYCLES+1); no wrap within a state.
// TESTING
//  T1 SNES_READ 1->0 from IDLE, RD_CYCLES=4 -> ROM_OE_N low 4 cycles, MODE=0, one ROM_DATA_TO_SNES_MEM
//     pulse on the 4th low cycle; no MCU_RDY.
//  T2 SNES_WRITE 1->0 -> SNES_DATA_TO_MEM 3 cycles after S_WR entry, then ROM_WE_N low exactly
//     4 cycles; OE stays high.
//  T3 MCU_WRQ pulse -> MCU_BUSY=1, MCU_DATA_TO_MEM at M_WR cnt 0, MODE=1, MCU_WRITE/ROM_WE_N low
//     4 cycles, then MCU_RDY single pulse and MCU_BUSY=0.
//  T4 MCU_RRQ and MCU_WRQ in the same cycle -> M_RD then M_WR, ROM_DATA_TO_MCU_MEM before
//     MCU_DATA_TO_MEM, exactly 2 MCU_RDY pulses.
//  T5 SNES_READ falls 1 cycle into M_WR -> M_WR completes, S_RD entered within 6 cycles of detect;
//     MODE 1->0 across one IDLE cycle.
//  T6 Assert RST_N=0 mid S_WR with ROM_WE_N low -> ROM_WE_N=1 with no CLK edge; after release
//     IDLE, no strobes, no spurious edge.

Source files
------------

// File: rtl/rom_access_seq.sv
// rom_access_seq: bus sequencer for the shared 16-bit ROM/SRAM.
// Arbitrates SNES and MCU accesses (SNES has fixed priority) and produces the
// registered control strobes for the data path plus the ROM_OE_N/ROM_WE_N pins.
module rom_access_seq #(
  parameter int RD_CYCLES = 4,  // OE low cycles per read; latch strobe on the last one
  parameter int WR_CYCLES = 4,  // WE low cycles per write
  parameter int WR_DELAY  = 3   // S_WR cycles before WE; SNES byte captured on the last of them
) (
  input  logic clk,
  input  logic rst_n,
  input  logic snes_read,
  input  logic snes_write,
  input  logic mcu_rrq,
  input  logic mcu_wrq,
  output logic mcu_rdy,
  output logic mcu_busy,
  output logic mode,
  output logic mcu_write,
  output logic rom_oe_n,
  output logic rom_we_n,
  output logic snes_data_to_mem,
  output logic mcu_data_to_mem,
  output logic rom_data_to_snes_mem,
  output logic rom_data_to_mcu_mem
);

  // The counter must hold the longest per-state count. With legal parameters the
  // SNES write span dominates; a long read setting still gets enough bits.
  localparam int SW_SPAN  = WR_DELAY + WR_CYCLES;
  localparam int CNT_MAX  = (RD_CYCLES > SW_SPAN) ? RD_CYCLES : SW_SPAN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RD_LAST = cnt_t'(RD_CYCLES - 1);
  localparam cnt_t WD_LAST = cnt_t'(WR_DELAY - 1);
  localparam cnt_t WE_FRST = cnt_t'(WR_DELAY);
  localparam cnt_t SW_LAST = cnt_t'(SW_SPAN - 1);
  localparam cnt_t MW_LAST = cnt_t'(WR_CYCLES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_RD = 3'd1,
    S_WR = 3'd2,
    M_RD = 3'd3,
    M_WR = 3'd4
  } state_t;

  state_t state, state_nxt;
  cnt_t   cnt, cnt_nxt;

  logic [2:0] rd_sync, wr_sync;
  logic       rd_fall, wr_fall;

  logic snes_rd_pend, snes_wr_pend, mcu_rd_pend, mcu_wr_pend;
  logic clr_snes_rd, clr_snes_wr, clr_mcu_rd, clr_mcu_wr;

  logic mode_nxt, mcu_write_nxt, oe_n_nxt, we_n_nxt;
  logic snes_mem_nxt, mcu_mem_nxt, rom_snes_nxt, rom_mcu_nxt, rdy_nxt;

  // Three-flop synchronisers for the asynchronous SNES strobes; preset to 1 so
  // leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync <= 3'b111;
      wr_sync <= 3'b111;
    end else begin
      rd_sync <= {rd_sync[1:0], snes_read};
      wr_sync <= {wr_sync[1:0], snes_write};
    end
  end

  // Falling edge seen between the 2nd and 3rd synchroniser flops.
  assign rd_fall = rd_sync[2] & ~rd_sync[1];
  assign wr_fall = wr_sync[2] & ~wr_sync[1];

  // Pending flags. SNES edges merge into an already-set flag; an MCU request
  // arriving while its flag is set is dropped, even on the cycle it is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snes_rd_pend <= 1'b0;
      snes_wr_pend <= 1'b0;
      mcu_rd_pend  <= 1'b0;
      mcu_wr_pend  <= 1'b0;
    end else begin
      snes_rd_pend <= (snes_rd_pend & ~clr_snes_rd) | rd_fall;
      snes_wr_pend <= (snes_wr_pend & ~clr_snes_wr) | wr_fall;
      mcu_rd_pend  <= (mcu_rd_pend & ~clr_mcu_rd) | (mcu_rrq & ~mcu_rd_pend);
      mcu_wr_pend  <= (mcu_wr_pend & ~clr_mcu_wr) | (mcu_wrq & ~mcu_wr_pend);
    end
  end

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: arbitration in IDLE, fixed-length access states that
  // always return to IDLE, which guarantees one idle cycle between accesses.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    clr_snes_rd = 1'b0;
    clr_snes_wr = 1'b0;
    clr_mcu_rd  = 1'b0;
    clr_mcu_wr  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (snes_rd_pend) begin
          state_nxt   = S_RD;
          clr_snes_rd = 1'b1;
        end else if (snes_wr_pend) begin
          state_nxt   = S_WR;
          clr_snes_wr = 1'b1;
        end else if (mcu_rd_pend) begin
          state_nxt  = M_RD;
          clr_mcu_rd = 1'b1;
        end else if (mcu_wr_pend) begin
          state_nxt  = M_WR;
          clr_mcu_wr = 1'b1;
        end
      end
      S_RD, M_RD: begin
        if (cnt == RD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      S_WR: begin
        if (cnt == SW_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      M_WR: begin
        if (cnt == MW_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state/count so every pin comes straight
  // from a flop. MODE keeps its value through IDLE and only moves when the
  // next access starts.
  always_comb begin
    mode_nxt      = mode;
    mcu_write_nxt = 1'b1;
    oe_n_nxt      = 1'b1;
    we_n_nxt      = 1'b1;
    snes_mem_nxt  = 1'b0;
    mcu_mem_nxt   = 1'b0;
    rom_snes_nxt  = 1'b0;
    rom_mcu_nxt   = 1'b0;
    rdy_nxt       = ((state == M_RD) || (state == M_WR)) && (state_nxt == IDLE);
    case (state_nxt)
      S_RD: begin
        mode_nxt     = 1'b0;
        oe_n_nxt     = 1'b0;
        rom_snes_nxt = (cnt_nxt == RD_LAST);
      end
      S_WR: begin
        mode_nxt     = 1'b0;
        snes_mem_nxt = (cnt_nxt == WD_LAST);
        we_n_nxt     = ~(cnt_nxt >= WE_FRST);
      end
      M_RD: begin
        mode_nxt    = 1'b1;
        oe_n_nxt    = 1'b0;
        rom_mcu_nxt = (cnt_nxt == RD_LAST);
      end
      M_WR: begin
        mode_nxt      = 1'b1;
        mcu_mem_nxt   = (cnt_nxt == '0);
        we_n_nxt      = (cnt_nxt == '0);
        mcu_write_nxt = (cnt_nxt == '0);
      end
      default: ;
    endcase
  end

  // Output register; async reset drops OE/WE immediately mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode                 <= 1'b0;
      mcu_write            <= 1'b1;
      rom_oe_n             <= 1'b1;
      rom_we_n             <= 1'b1;
      snes_data_to_mem     <= 1'b0;
      mcu_data_to_mem      <= 1'b0;
      rom_data_to_snes_mem <= 1'b0;
      rom_data_to_mcu_mem  <= 1'b0;
      mcu_rdy              <= 1'b0;
    end else begin
      mode                 <= mode_nxt;
      mcu_write            <= mcu_write_nxt;
      rom_oe_n             <= oe_n_nxt;
      rom_we_n             <= we_n_nxt;
      snes_data_to_mem     <= snes_mem_nxt;
      mcu_data_to_mem      <= mcu_mem_nxt;
      rom_data_to_snes_mem <= rom_snes_nxt;
      rom_data_to_mcu_mem  <= rom_mcu_nxt;
      mcu_rdy              <= rdy_nxt;
    end
  end

  assign mcu_busy = mcu_rd_pend | mcu_wr_pend | (state == M_RD) | (state == M_WR);

endmodule

// File: tb/tb_rom_access_seq.sv
// Testbench for rom_access_seq: directed accesses, expected output events
// queued by the stimulus, compared by an independent monitor.
module tb_rom_access_seq;

  localparam int EV_SNES_MEM = 0;
  localparam int EV_MCU_MEM  = 1;
  localparam int EV_ROM_SNES = 2;
  localparam int EV_ROM_MCU  = 3;
  localparam int EV_RDY      = 4;
  localparam int EV_BUSY     = 5;
  localparam int EV_OE       = 6;
  localparam int EV_WE       = 7;
  localparam int EV_MW       = 8;
  localparam int EV_MODE     = 9;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snes_read = 1'b1;
  logic snes_write = 1'b1;
  logic mcu_rrq = 1'b0;
  logic mcu_wrq = 1'b0;
  logic mcu_rdy, mcu_busy, mode, mcu_write, rom_oe_n, rom_we_n;
  logic snes_data_to_mem, mcu_data_to_mem, rom_data_to_snes_mem, rom_data_to_mcu_mem;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  ev_t exp_q[$];

  rom_access_seq #(.RD_CYCLES(4), .WR_CYCLES(4), .WR_DELAY(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .snes_read(snes_read),
    .snes_write(snes_write),
    .mcu_rrq(mcu_rrq),
    .mcu_wrq(mcu_wrq),
    .mcu_rdy(mcu_rdy),
    .mcu_busy(mcu_busy),
    .mode(mode),
    .mcu_write(mcu_write),
    .rom_oe_n(rom_oe_n),
    .rom_we_n(rom_we_n),
    .snes_data_to_mem(snes_data_to_mem),
    .mcu_data_to_mem(mcu_data_to_mem),
    .rom_data_to_snes_mem(rom_data_to_snes_mem),
    .rom_data_to_mcu_mem(rom_data_to_mcu_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_SNES_MEM: return "snes_data_to_mem";
      EV_MCU_MEM:  return "mcu_data_to_mem";
      EV_ROM_SNES: return "rom_data_to_snes_mem";
      EV_ROM_MCU:  return "rom_data_to_mcu_mem";
      EV_RDY:      return "mcu_rdy";
      EV_BUSY:     return "mcu_busy_change";
      EV_OE:       return "oe_low_run";
      EV_WE:       return "we_low_run";
      EV_MW:       return "mcu_write_low_run";
      EV_MODE:     return "mode_change";
      default:     return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Compare one observed event against the head of the expected queue.
  task automatic got(input int kind, input int val);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_%s: got val=%0d at cyc %0d, required no event", kname(kind), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        mismatched++;
        $display("FAIL %s: got %s val=%0d cyc=%0d, required %s val=%0d cyc=%0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT outputs into events (pulses, busy/mode changes, run
  // lengths of OE/WE/MCU_WRITE low) and checks bus invariants every cycle.
  initial begin
    int  oe_run, we_run, mw_run;
    logic mode_prev, busy_prev;
    oe_run = 0; we_run = 0; mw_run = 0;
    mode_prev = 1'b0; busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        oe_run = 0; we_run = 0; mw_run = 0;
        mode_prev = mode;
        busy_prev = mcu_busy;
      end else begin
        compared++;
        if ((!rom_oe_n && !rom_we_n) ||
            ($countones({snes_data_to_mem, mcu_data_to_mem,
                         rom_data_to_snes_mem, rom_data_to_mcu_mem}) > 1)) begin
          mismatched++;
          $display("FAIL bus_invariant: got oe_n=%0b we_n=%0b strobes=%b at cyc %0d, required exclusive",
                   rom_oe_n, rom_we_n, {snes_data_to_mem, mcu_data_to_mem,
                   rom_data_to_snes_mem, rom_data_to_mcu_mem}, cyc);
        end
        if (snes_data_to_mem)     got(EV_SNES_MEM, 1);
        if (mcu_data_to_mem)      got(EV_MCU_MEM, 1);
        if (rom_data_to_snes_mem) got(EV_ROM_SNES, 1);
        if (rom_data_to_mcu_mem)  got(EV_ROM_MCU, 1);
        if (mcu_rdy)              got(EV_RDY, 1);
        if (mcu_busy !== busy_prev) begin
          got(EV_BUSY, int'(mcu_busy));
          busy_prev = mcu_busy;
        end
        if (!rom_oe_n) oe_run++;
        else if (oe_run > 0) begin got(EV_OE, oe_run); oe_run = 0; end
        if (!rom_we_n) we_run++;
        else if (we_run > 0) begin got(EV_WE, we_run); we_run = 0; end
        if (!mcu_write) mw_run++;
        else if (mw_run > 0) begin got(EV_MW, mw_run); mw_run = 0; end
        if (mode !== mode_prev) begin
          got(EV_MODE, int'(mode));
          mode_prev = mode;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: drive on the falling edge, queue hand-derived events relative
  // to the cycle of the drive.
  initial begin
    int c0;
    ev_t e;

    // Reset values
    wait_cyc(3);
    chk("reset_mode", mode, 0);
    chk("reset_mcu_write", mcu_write, 1);
    chk("reset_oe_n", rom_oe_n, 1);
    chk("reset_we_n", rom_we_n, 1);
    chk("reset_strobes", {snes_data_to_mem, mcu_data_to_mem, rom_data_to_snes_mem,
                          rom_data_to_mcu_mem, mcu_rdy, mcu_busy}, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // T1: SNES read
    c0 = cyc;
    snes_read = 1'b0;
    push(EV_ROM_SNES, 1, c0 + 7);
    push(EV_OE, 4, c0 + 8);
    wait_cyc(12);
    snes_read = 1'b1;
    wait_cyc(8);

    // T2: SNES write
    c0 = cyc;
    snes_write = 1'b0;
    push(EV_SNES_MEM, 1, c0 + 6);
    push(EV_WE, 4, c0 + 11);
    wait_cyc(14);
    snes_write = 1'b1;
    wait_cyc(8);

    // T3: MCU write
    c0 = cyc;
    mcu_wrq = 1'b1;
    push(EV_BUSY, 1, c0 + 1);
    push(EV_MCU_MEM, 1, c0 + 2);
    push(EV_MODE, 1, c0 + 2);
    push(EV_RDY, 1, c0 + 7);
    push(EV_BUSY, 0, c0 + 7);
    push(EV_WE, 4, c0 + 7);
    push(EV_MW, 4, c0 + 7);
    wait_cyc(1);
    mcu_wrq = 1'b0;
    wait_cyc(15);

    // T4: simultaneous MCU read and write requests; MODE already 1
    c0 = cyc;
    mcu_rrq = 1'b1;
    mcu_wrq = 1'b1;
    push(EV_BUSY, 1, c0 + 1);
    push(EV_ROM_MCU, 1, c0 + 5);
    push(EV_RDY, 1, c0 + 6);
    push(EV_OE, 4, c0 + 6);
    push(EV_MCU_MEM, 1, c0 + 7);
    push(EV_RDY, 1, c0 + 12);
    push(EV_BUSY, 0, c0 + 12);
    push(EV_WE, 4, c0 + 12);
    push(EV_MW, 4, c0 + 12);
    wait_cyc(1);
    mcu_rrq = 1'b0;
    mcu_wrq = 1'b0;
    wait_cyc(20);

    // T5: SNES read falls during M_WR; served after one IDLE cycle
    c0 = cyc;
    mcu_wrq = 1'b1;
    push(EV_BUSY, 1, c0 + 1);
    push(EV_MCU_MEM, 1, c0 + 2);
    push(EV_RDY, 1, c0 + 7);
    push(EV_BUSY, 0, c0 + 7);
    push(EV_WE, 4, c0 + 7);
    push(EV_MW, 4, c0 + 7);
    push(EV_MODE, 0, c0 + 8);
    push(EV_ROM_SNES, 1, c0 + 11);
    push(EV_OE, 4, c0 + 12);
    wait_cyc(1);
    mcu_wrq = 1'b0;
    wait_cyc(1);
    snes_read = 1'b0;
    wait_cyc(16);
    snes_read = 1'b1;
    wait_cyc(8);

    // T7: repeated MCU write request while pending is dropped
    c0 = cyc;
    mcu_wrq = 1'b1;
    push(EV_BUSY, 1, c0 + 1);
    push(EV_MCU_MEM, 1, c0 + 2);
    push(EV_MODE, 1, c0 + 2);
    push(EV_RDY, 1, c0 + 7);
    push(EV_BUSY, 0, c0 + 7);
    push(EV_WE, 4, c0 + 7);
    push(EV_MW, 4, c0 + 7);
    wait_cyc(2);
    mcu_wrq = 1'b0;
    wait_cyc(15);

    // T6: asynchronous reset in the middle of the SNES write pulse
    c0 = cyc;
    snes_write = 1'b0;
    push(EV_MODE, 0, c0 + 4);
    push(EV_SNES_MEM, 1, c0 + 6);
    wait_cyc(8);
    chk("t6_we_low_before_reset", rom_we_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we_n_async", rom_we_n, 1);
    chk("t6_oe_n_async", rom_oe_n, 1);
    chk("t6_mode_async", mode, 0);
    chk("t6_mcu_write_async", mcu_write, 1);
    chk("t6_strobes_async", {snes_data_to_mem, mcu_data_to_mem, rom_data_to_snes_mem,
                             rom_data_to_mcu_mem, mcu_rdy, mcu_busy}, 0);
    snes_write = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("t6_idle_we_n", rom_we_n, 1);

    // Sequencer still serves a read after the reset
    c0 = cyc;
    snes_read = 1'b0;
    push(EV_ROM_SNES, 1, c0 + 7);
    push(EV_OE, 4, c0 + 8);
    wait_cyc(12);
    snes_read = 1'b1;
    wait_cyc(10);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_%s: got nothing, required val=%0d at cyc %0d", kname(e.kind), e.val, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
